// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// hazard_control_unit_if : ID-stage decode fields in, hazard controls out.
// Revision: 1.0
// ============================================================================
interface hazard_control_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic [REG_BITS-1:0] id_dst;
    logic                id_reg_write;
    logic                id_mem_read;
    logic [1:0]          id_jump;
    logic                ex_branch_taken;
    logic                stall;
    logic                flush_if;
    logic                flush_id;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                jr_fwd;
    logic [CNT_BITS-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
               id_jump, ex_branch_taken,
        input  stall, flush_if, flush_id, fwd_a, fwd_b, jr_fwd, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
               id_jump, ex_branch_taken,
        output stall, flush_if, flush_id, fwd_a, fwd_b, jr_fwd, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// hazard_control_unit : stall/flush/forwarding control for a 5-stage pipeline.
// Revision: 1.0
// ============================================================================
module hazard_control_unit #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    hazard_control_unit_if.slave bus
);
    localparam logic [CNT_BITS-1:0] c_cnt_max = '1;
    localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);

    logic                ex_valid_q,  ex_rw_q,  ex_mr_q;
    logic [REG_BITS-1:0] ex_dst_q,    ex_rs_q,  ex_rt_q;
    logic                ex_valid_d,  ex_rw_d,  ex_mr_d;
    logic [REG_BITS-1:0] ex_dst_d,    ex_rs_d,  ex_rt_d;
    logic                mem_valid_q, mem_rw_q, mem_mr_q;
    logic [REG_BITS-1:0] mem_dst_q;
    logic                wb_valid_q,  wb_rw_q;
    logic [REG_BITS-1:0] wb_dst_q;
    logic [CNT_BITS-1:0] stall_count_q, stall_count_d;

    logic w_id_valid, w_branch, w_jump;
    logic w_ex_wr_rs, w_ex_wr_rt, w_mem_wr_rs;
    logic w_load_use, w_jr_stall, w_stall;

    function automatic logic writes_reg(input logic v, input logic rw,
                                        input logic [REG_BITS-1:0] dst,
                                        input logic [REG_BITS-1:0] r);
        return v & rw & (dst == r) & (r != '0);
    endfunction

    // Inputs are masked while in reset so every output reads 0.
    assign w_id_valid  = bus.id_valid & reset_n;
    assign w_branch    = bus.ex_branch_taken & reset_n;
    assign w_jump      = w_id_valid & (bus.id_jump != 2'b00);

    assign w_ex_wr_rs  = writes_reg(ex_valid_q,  ex_rw_q,  ex_dst_q,  bus.id_rs);
    assign w_ex_wr_rt  = writes_reg(ex_valid_q,  ex_rw_q,  ex_dst_q,  bus.id_rt);
    assign w_mem_wr_rs = writes_reg(mem_valid_q, mem_rw_q, mem_dst_q, bus.id_rs);

    assign w_load_use  = w_id_valid & ex_mr_q & (w_ex_wr_rs | w_ex_wr_rt);
    // A load ahead of a JR stalls until it has left MEM: two cycles from EX.
    assign w_jr_stall  = w_jump & ((w_ex_wr_rs & ex_mr_q) | (w_mem_wr_rs & mem_mr_q));
    assign w_stall     = ~w_branch & (w_load_use | w_jr_stall);

    assign bus.stall       = w_stall;
    assign bus.flush_if    = w_branch | (w_jump & ~w_stall);
    assign bus.flush_id    = w_branch;
    assign bus.jr_fwd      = w_jump & w_ex_wr_rs & ~ex_mr_q;
    assign bus.stall_count = stall_count_q;

    always_comb begin
        bus.fwd_a = 2'b00;
        if (writes_reg(mem_valid_q, mem_rw_q, mem_dst_q, ex_rs_q))
            bus.fwd_a = 2'b10;
        else if (writes_reg(wb_valid_q, wb_rw_q, wb_dst_q, ex_rs_q))
            bus.fwd_a = 2'b01;
    end

    always_comb begin
        bus.fwd_b = 2'b00;
        if (writes_reg(mem_valid_q, mem_rw_q, mem_dst_q, ex_rt_q))
            bus.fwd_b = 2'b10;
        else if (writes_reg(wb_valid_q, wb_rw_q, wb_dst_q, ex_rt_q))
            bus.fwd_b = 2'b01;
    end

    // A bubble is a fully cleared record so it can never drive forwarding.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        ex_dst_d   = '0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        if (!(w_stall || w_branch)) begin
            ex_valid_d = w_id_valid;
            ex_rw_d    = bus.id_reg_write;
            ex_mr_d    = bus.id_mem_read;
            ex_dst_d   = bus.id_dst;
            ex_rs_d    = bus.id_rs;
            ex_rt_d    = bus.id_rt;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (w_stall && (stall_count_q != c_cnt_max))
            stall_count_d = stall_count_q + c_cnt_one;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_rw_q       <= 1'b0;
            ex_mr_q       <= 1'b0;
            ex_dst_q      <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            mem_valid_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_mr_q      <= 1'b0;
            mem_dst_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_rw_q       <= 1'b0;
            wb_dst_q      <= '0;
            stall_count_q <= '0;
        end else begin
            wb_valid_q    <= mem_valid_q;
            wb_rw_q       <= mem_rw_q;
            wb_dst_q      <= mem_dst_q;
            mem_valid_q   <= ex_valid_q;
            mem_rw_q      <= ex_rw_q;
            mem_mr_q      <= ex_mr_q;
            mem_dst_q     <= ex_dst_q;
            ex_valid_q    <= ex_valid_d;
            ex_rw_q       <= ex_rw_d;
            ex_mr_q       <= ex_mr_d;
            ex_dst_q      <= ex_dst_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_control_unit : directed + random stimulus against a pipeline model.
// Revision: 1.0
// ============================================================================
module tb_hazard_control_unit;
    localparam int RB = 5;

    typedef struct packed {
        bit       v;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
        bit [4:0] rs;
        bit [4:0] rt;
    } rec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       d_valid, d_rw, d_mr, d_br;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_jump;

    hazard_control_unit_if #(.REG_BITS(RB), .CNT_BITS(16)) bus ();
    hazard_control_unit_if #(.REG_BITS(RB), .CNT_BITS(5))  bus_s ();

    assign bus.id_valid          = d_valid;
    assign bus.id_rs             = d_rs;
    assign bus.id_rt             = d_rt;
    assign bus.id_dst            = d_dst;
    assign bus.id_reg_write      = d_rw;
    assign bus.id_mem_read       = d_mr;
    assign bus.id_jump           = d_jump;
    assign bus.ex_branch_taken   = d_br;
    assign bus_s.id_valid        = d_valid;
    assign bus_s.id_rs           = d_rs;
    assign bus_s.id_rt           = d_rt;
    assign bus_s.id_dst          = d_dst;
    assign bus_s.id_reg_write    = d_rw;
    assign bus_s.id_mem_read     = d_mr;
    assign bus_s.id_jump         = d_jump;
    assign bus_s.ex_branch_taken = d_br;

    hazard_control_unit #(.REG_BITS(RB), .CNT_BITS(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
    hazard_control_unit #(.REG_BITS(RB), .CNT_BITS(5)) u_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus_s));

    rec_t m_ex, m_mem, m_wb;
    int   m_cnt, m_cnt_s;
    int   tests = 0;
    int   fails = 0;

    function automatic bit wr(rec_t r, bit [4:0] x);
        return r.v && r.rw && (r.dst == x) && (x != 5'd0);
    endfunction

    function automatic bit [1:0] fwd_sel(bit [4:0] x);
        if (wr(m_mem, x)) return 2'b10;
        if (wr(m_wb, x))  return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] dst,
                         input bit rw, input bit mr, input bit [1:0] j, input bit br);
        d_valid = v; d_rs = rs; d_rt = rt; d_dst = dst;
        d_rw = rw; d_mr = mr; d_jump = j; d_br = br;
    endtask

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {bus.stall, bus.flush_if, bus.flush_id, bus.jr_fwd,
                               bus.fwd_a, bus.fwd_b, bus_s.stall, bus_s.flush_if}, 32'd0);
        check({tag, "_cnt"}, {bus.stall_count, 11'd0, bus_s.stall_count}, 32'd0);
    endtask

    // One pipeline cycle: predict outputs from the current ID inputs, check, advance.
    task automatic step();
        bit jump, lu, js, e_stall, e_fif, e_jr;
        @(negedge clk);
        jump    = d_valid && (d_jump != 2'b00);
        lu      = d_valid && m_ex.mr && (wr(m_ex, d_rs) || wr(m_ex, d_rt));
        js      = jump && ((wr(m_ex, d_rs) && m_ex.mr) || (wr(m_mem, d_rs) && m_mem.mr));
        e_stall = !d_br && (lu || js);
        e_fif   = d_br || (jump && !e_stall);
        e_jr    = jump && wr(m_ex, d_rs) && !m_ex.mr;
        check("ctrl", {bus.stall, bus.flush_if, bus.flush_id, bus.jr_fwd},
                      {e_stall, e_fif, d_br, e_jr});
        check("fwd", {bus.fwd_a, bus.fwd_b}, {fwd_sel(m_ex.rs), fwd_sel(m_ex.rt)});
        check("cnt", bus.stall_count, m_cnt);
        check("cnt_sat", bus_s.stall_count, m_cnt_s);
        @(posedge clk);
        m_wb  = m_mem;
        m_mem = m_ex;
        if (e_stall || d_br) m_ex = '0;
        else m_ex = '{v: d_valid, dst: d_dst, rw: d_rw, mr: d_mr, rs: d_rs, rt: d_rt};
        if (e_stall) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 31) m_cnt_s++;
        end
        #1;
    endtask

    initial begin
        // Reset with busy inputs: outputs must read 0 asynchronously.
        reset_n = 1'b0;
        drive(1, 5'd8, 5'd8, 5'd8, 1, 1, 2'b01, 1);
        model_reset();
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        step();

        // Load-use: lw $8 then add rs=8 (one stall, then WB forward).
        drive(1, 5'd1, 5'd8, 5'd8, 1, 1, 2'b00, 0); step();
        drive(1, 5'd8, 5'd2, 5'd10, 1, 0, 2'b00, 0); step(); step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step(); step();

        // Back-to-back ALU forwarding from MEM and then WB.
        drive(1, 5'd1, 5'd2, 5'd9, 1, 0, 2'b00, 0); step();
        drive(1, 5'd9, 5'd9, 5'd11, 1, 0, 2'b00, 0); step();
        drive(1, 5'd3, 5'd4, 5'd12, 1, 0, 2'b00, 0); step();
        drive(1, 5'd9, 5'd5, 5'd13, 1, 0, 2'b00, 0); step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step(); step();

        // Writes to $0 never forward.
        drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 2'b00, 0); step();
        drive(1, 5'd0, 5'd0, 5'd14, 1, 0, 2'b00, 0); step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step(); step();

        // JR after ALU producer: forward; after load producer: two stalls.
        drive(1, 5'd1, 5'd2, 5'd31, 1, 0, 2'b00, 0); step();
        drive(1, 5'd31, 5'd0, 5'd0, 0, 0, 2'b01, 0); step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step(); step();
        drive(1, 5'd1, 5'd31, 5'd31, 1, 1, 2'b00, 0); step();
        drive(1, 5'd31, 5'd0, 5'd0, 0, 0, 2'b10, 0); step(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step(); step();

        // Branch overrides a load-use hazard in the same cycle.
        drive(1, 5'd1, 5'd8, 5'd8, 1, 1, 2'b00, 0); step();
        drive(1, 5'd8, 5'd2, 5'd10, 1, 0, 2'b01, 1); step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step(); step();

        // Continuous JR-after-load pattern drives the narrow counter to saturation.
        drive(1, 5'd31, 5'd0, 5'd31, 1, 1, 2'b01, 0);
        for (int i = 0; i < 60; i++) step();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0); step();

        // Reset asserted mid-stall drops everything immediately.
        drive(1, 5'd1, 5'd8, 5'd8, 1, 1, 2'b00, 0); step();
        drive(1, 5'd8, 5'd2, 5'd10, 1, 0, 2'b00, 0);
        check("pre_reset_stall", bus.stall, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(); step();

        // Random traffic on a small register set to make hazards frequent.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 8,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'b00,
                  $urandom_range(0, 19) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
